// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter family:
// FSM state encoding and the value driven while the display is blanked.
package seg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] SEG_BLANK_VAL = 8'd0;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle of the seven-segment arbiter. The arbiter takes the
// slave view; the requester side and the display top take the master view.
interface seg_display_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OWN_W = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]   REQ;
  logic [8*N_REQ-1:0] VALUE;
  logic [N_REQ-1:0]   GNT;
  logic [7:0]         DISP_VALUE;
  logic               DISP_VALID;
  logic [OWN_W-1:0]   DISP_OWNER;

  modport master (
    output REQ, VALUE,
    input  GNT, DISP_VALUE, DISP_VALID, DISP_OWNER
  );

  modport slave (
    input  REQ, VALUE,
    output GNT, DISP_VALUE, DISP_VALID, DISP_OWNER
  );

endinterface

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin picker: first set request bit strictly after ptr, wrapping, so
// the requester at ptr itself is chosen only when nobody else is requesting.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OWN_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic             found,
  output logic [OWN_W-1:0] idx
);

  logic [OWN_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = OWN_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 3-digit seven-segment path,
// with a minimum dwell per owner and a blanking gap on every handover.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DWELL_CYCLES = 200,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned OWN_W        = $clog2(N_REQ)
) (
  input logic                  CLK,
  input logic                  N_Reset,
  seg_display_arbiter_if.slave bus
);

  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [1:0]       state, state_n;
  logic [OWN_W-1:0] owner, owner_n;
  logic [OWN_W-1:0] ptr, ptr_n;
  logic [DW-1:0]    dwell, dwell_n;
  logic [BW-1:0]    blank, blank_n;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic [7:0]       disp_value, disp_value_n;
  logic             disp_valid, disp_valid_n;
  logic [OWN_W-1:0] disp_owner, disp_owner_n;

  logic [7:0]       vals [N_REQ];
  logic [OWN_W-1:0] pick_ptr;
  logic             found;
  logic [OWN_W-1:0] idx;
  logic [N_REQ-1:0] owner_mask;
  logic             owner_req;
  logic             other_req;
  logic             dwell_done;
  logic             blank_done;
  logic             decide;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      vals[i] = bus.VALUE[8*i +: 8];
    end
  end

  // While releasing from SHOW with no blank phase, the pointer update to the
  // ex-owner has not landed yet, so the picker looks from the owner directly.
  assign pick_ptr = (state == ST_SHOW) ? owner : ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req   (bus.REQ),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (idx)
  );

  assign owner_mask = N_REQ'(1) << owner;
  assign owner_req  = |(bus.REQ & owner_mask);
  assign other_req  = |(bus.REQ & ~owner_mask);
  assign dwell_done = (dwell == DW'(DWELL_CYCLES - 1));
  assign blank_done = (blank == BW'(BLANK_CYCLES - 1));

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    ptr_n        = ptr;
    dwell_n      = dwell;
    blank_n      = blank;
    gnt_n        = gnt;
    disp_value_n = disp_value;
    disp_valid_n = disp_valid;
    disp_owner_n = disp_owner;
    decide       = 1'b0;

    case (state)
      ST_IDLE: decide = 1'b1;

      ST_SHOW: begin
        if (!owner_req || (dwell_done && other_req)) begin
          ptr_n        = owner;
          gnt_n        = '0;
          disp_valid_n = 1'b0;
          disp_value_n = SEG_BLANK_VAL;
          blank_n      = '0;
          if (BLANK_CYCLES > 0) begin
            state_n = ST_BLANK;
          end else begin
            state_n = ST_IDLE;
            decide  = 1'b1;
          end
        end else begin
          disp_value_n = vals[owner];
          if (!dwell_done) dwell_n = dwell + DW'(1);
        end
      end

      ST_BLANK: begin
        if (blank_done) begin
          state_n = ST_IDLE;
          decide  = 1'b1;
        end else begin
          blank_n = blank + BW'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Shared grant path for IDLE, end of BLANK, and zero-blank handover.
    if (decide && found) begin
      state_n      = ST_SHOW;
      owner_n      = idx;
      gnt_n        = N_REQ'(1) << idx;
      disp_valid_n = 1'b1;
      disp_owner_n = idx;
      disp_value_n = vals[idx];
      dwell_n      = '0;
    end
  end

  always_ff @(posedge CLK or negedge N_Reset) begin
    if (!N_Reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      ptr        <= OWN_W'(N_REQ - 1);
      dwell      <= '0;
      blank      <= '0;
      gnt        <= '0;
      disp_value <= SEG_BLANK_VAL;
      disp_valid <= 1'b0;
      disp_owner <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      ptr        <= ptr_n;
      dwell      <= dwell_n;
      blank      <= blank_n;
      gnt        <= gnt_n;
      disp_value <= disp_value_n;
      disp_valid <= disp_valid_n;
      disp_owner <= disp_owner_n;
    end
  end

  assign bus.GNT        = gnt;
  assign bus.DISP_VALUE = disp_value;
  assign bus.DISP_VALID = disp_valid;
  assign bus.DISP_OWNER = disp_owner;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter with N_REQ=4, dwell 4, blank 2.
module tb_seg_display_arbiter;

  logic CLK = 1'b0;
  logic N_Reset;

  always #5 CLK = ~CLK;

  seg_display_arbiter_if #(.N_REQ(4)) bus ();

  seg_display_arbiter #(
    .N_REQ        (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK     (CLK),
    .N_Reset (N_Reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [7:0] value;
    logic [1:0] owner;
  } exp_t;

  exp_t  sb [$];
  string tag;
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check_head();
    exp_t e;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      assert (bus.GNT === e.gnt) else begin
        miscompares++;
        $error("FAIL %s GNT: got %b expected %b", tag, bus.GNT, e.gnt);
      end
      vectors++;
      assert (bus.DISP_VALID === e.valid) else begin
        miscompares++;
        $error("FAIL %s DISP_VALID: got %b expected %b", tag, bus.DISP_VALID, e.valid);
      end
      vectors++;
      assert (bus.DISP_VALUE === e.value) else begin
        miscompares++;
        $error("FAIL %s DISP_VALUE: got %0d expected %0d", tag, bus.DISP_VALUE, e.value);
      end
      if (e.valid) begin
        vectors++;
        assert (bus.DISP_OWNER === e.owner) else begin
          miscompares++;
          $error("FAIL %s DISP_OWNER: got %0d expected %0d", tag, bus.DISP_OWNER, e.owner);
        end
      end
    end
  endtask

  task automatic now(input logic [3:0] g, input logic v, input logic [7:0] val,
                     input logic [1:0] o);
    sb.push_back('{g, v, val, o});
    check_head();
  endtask

  task automatic cyc(input logic [3:0] g, input logic v, input logic [7:0] val,
                     input logic [1:0] o);
    sb.push_back('{g, v, val, o});
    @(posedge CLK);
    #1;
    check_head();
  endtask

  task automatic shows(input int own, input logic [7:0] val, input int n);
    for (int i = 0; i < n; i++) cyc(4'(1 << own), 1'b1, val, 2'(own));
  endtask

  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, 8'd0, 2'd0);
  endtask

  initial begin
    logic [7:0] vals [4];
    vals[0] = 8'd11; vals[1] = 8'd22; vals[2] = 8'd33; vals[3] = 8'd44;

    N_Reset   = 1'b0;
    bus.REQ   = 4'hF;
    bus.VALUE = {vals[3], vals[2], vals[1], vals[0]};

    tag = "reset_async";
    #2;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    tag = "reset_held";
    @(posedge CLK);
    #1;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    N_Reset = 1'b1;

    // First grant lands one edge after release; then strict rotation.
    tag = "rotation";
    for (int k = 0; k < 5; k++) begin
      shows(k % 4, vals[k % 4], 4);
      if (k < 4) blanks(2);
    end

    tag = "early_release";
    blanks(2);
    shows(1, vals[1], 2);
    bus.REQ = 4'b1000;
    blanks(2);
    cyc(4'b1000, 1'b1, vals[3], 2'd3);

    tag = "live_value";
    bus.VALUE[31:24] = 8'd99;
    bus.VALUE[7:0]   = 8'd200;
    cyc(4'b1000, 1'b1, 8'd99, 2'd3);
    shows(3, 8'd99, 5);

    tag = "wrap_skip";
    bus.REQ = 4'b1001;
    blanks(2);
    cyc(4'b0001, 1'b1, 8'd200, 2'd0);
    shows(0, 8'd200, 3);
    blanks(1);
    bus.REQ = 4'b0001;
    blanks(1);
    tag = "regrant_ex_owner";
    cyc(4'b0001, 1'b1, 8'd200, 2'd0);

    tag = "single_req";
    bus.VALUE[23:16] = 8'd173;
    bus.REQ = 4'b0100;
    blanks(2);
    cyc(4'b0100, 1'b1, 8'd173, 2'd2);
    shows(2, 8'd173, 10);

    tag = "idle";
    bus.REQ = 4'b0000;
    blanks(4);
    bus.REQ = 4'b0010;
    tag = "idle_grant";
    cyc(4'b0010, 1'b1, vals[1], 2'd1);

    tag = "reset_mid_blank";
    bus.REQ = 4'b0000;
    blanks(1);
    #3;
    N_Reset = 1'b0;
    bus.REQ = 4'hF;
    #1;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    @(posedge CLK);
    #1;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    N_Reset = 1'b1;
    tag = "grant_after_reset1";
    cyc(4'b0001, 1'b1, 8'd200, 2'd0);

    tag = "reset_mid_show";
    shows(0, 8'd200, 1);
    #3;
    N_Reset = 1'b0;
    #1;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    @(posedge CLK);
    #1;
    now(4'b0000, 1'b0, 8'd0, 2'd0);
    N_Reset = 1'b1;
    tag = "grant_after_reset2";
    cyc(4'b0001, 1'b1, 8'd200, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
